// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the shield bank and its channels.
// Optional repair timeout is enabled with SHIELD_REPAIR_TIMEOUT_EN.
package nexys_starship_pkg;

    localparam int TICK_W = 8;

    typedef enum logic [3:0] {
        CH_IDLE   = 4'b0001,
        CH_ARMING = 4'b0010,
        CH_ARMED  = 4'b0100,
        CH_BROKEN = 4'b1000
    } chan_state_e;

    typedef enum logic [1:0] {
        G_INIT = 2'b01,
        G_PLAY = 2'b10
    } game_state_e;

endpackage

// File: rtl/nexys_starship_shield_chan.sv
// One shield channel: arm delay, break latch, repair check.
// Repair timeout counter exists only with SHIELD_REPAIR_TIMEOUT_EN.
import nexys_starship_pkg::*;

module nexys_starship_shield_chan #(
    parameter int COMBO_W      = 4,
    parameter int ARM_TICKS    = 2,
    parameter int REPAIR_TICKS = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               start,
    input  logic               tick,
    input  logic               grant,
    input  logic [COMBO_W-1:0] random_hex,
    input  logic               repair_btn,
    input  logic [COMBO_W-1:0] hex_combo,
    output logic               armed,
    output logic               broken,
    output logic [COMBO_W-1:0] combo,
    output logic               mismatch,
    output logic               hull_breach
);

    localparam logic [TICK_W-1:0] ARM_LIM = TICK_W'(ARM_TICKS);

    chan_state_e        st_q, st_d;
    logic [TICK_W-1:0]  cnt_q, cnt_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic               match;

    assign match    = (hex_combo == combo_q);
    assign armed    = (st_q == CH_ARMED);
    assign broken   = (st_q == CH_BROKEN);
    assign combo    = combo_q;
    assign mismatch = broken && repair_btn && !match && !clear;

    // Next-state logic: game clear beats repair beats break
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        combo_d = combo_q;
        if (clear) begin
            st_d    = CH_IDLE;
            cnt_d   = '0;
            combo_d = '0;
        end else begin
            unique case (st_q)
                CH_IDLE: begin
                    if (start) begin
                        st_d  = CH_ARMING;
                        cnt_d = '0;
                    end
                end
                CH_ARMING: begin
                    if (tick && cnt_q != ARM_LIM) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == ARM_LIM) begin
                            st_d = CH_ARMED;
                        end
                    end
                end
                CH_ARMED: begin
                    if (grant) begin
                        st_d    = CH_BROKEN;
                        combo_d = random_hex;
                    end
                end
                CH_BROKEN: begin
                    if (repair_btn && match) begin
                        st_d  = CH_ARMING;
                        cnt_d = '0;
                    end
                end
                default: begin
                    st_d  = CH_IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Channel state, arm counter and latched combo
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= CH_IDLE;
            cnt_q   <= '0;
            combo_q <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            combo_q <= combo_d;
        end
    end

`ifdef SHIELD_REPAIR_TIMEOUT_EN
    localparam logic [TICK_W-1:0] REP_LIM = TICK_W'(REPAIR_TICKS);

    logic [TICK_W-1:0] rep_q, rep_d;
    logic              hb_q, hb_d;

    // Deadline counter runs only while the channel stays broken
    always_comb begin
        rep_d = rep_q;
        hb_d  = 1'b0;
        if (clear || st_q != CH_BROKEN || st_d != CH_BROKEN) begin
            rep_d = '0;
        end else if (tick) begin
            if (rep_q + 8'd1 == REP_LIM) begin
                rep_d = '0;
                hb_d  = 1'b1;
            end else begin
                rep_d = rep_q + 8'd1;
            end
        end
    end

    // Deadline counter and breach pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q <= '0;
            hb_q  <= 1'b0;
        end else begin
            rep_q <= rep_d;
            hb_q  <= hb_d;
        end
    end

    assign hull_breach = hb_q;
`else
    logic unused_repair;
    assign unused_repair = ^REPAIR_TICKS;
    assign hull_breach   = 1'b0;
`endif

endmodule

// File: rtl/nexys_starship_shield_bank.sv
// Bank of shield channels behind one game FSM with break arbitration.
// Optional repair timeout is enabled with SHIELD_REPAIR_TIMEOUT_EN.
import nexys_starship_pkg::*;

module nexys_starship_shield_bank #(
    parameter int NUM_SHIELDS  = 4,
    parameter int COMBO_W      = 4,
    parameter int ARM_TICKS    = 2,
    parameter int REPAIR_TICKS = 30
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             timer_tick,
    input  logic                             play_flag,
    input  logic                             gameover_ctrl,
    input  logic [NUM_SHIELDS-1:0]           break_req,
    input  logic [COMBO_W-1:0]               random_hex,
    input  logic [NUM_SHIELDS-1:0]           repair_btn,
    input  logic [COMBO_W-1:0]               hex_combo,
    output logic                             q_Init,
    output logic                             q_Play,
    output logic [NUM_SHIELDS-1:0]           broken,
    output logic [NUM_SHIELDS*COMBO_W-1:0]   combo_flat,
    output logic [$clog2(NUM_SHIELDS+1)-1:0] broken_count,
    output logic                             all_broken,
    output logic                             wrong_combo,
    output logic                             hull_breach
);

    localparam int CNT_W = $clog2(NUM_SHIELDS + 1);

    game_state_e             game_q, game_d;
    logic                    start, clear;
    logic [NUM_SHIELDS-1:0]  armed, grant, mismatch, hb;
    logic [CNT_W-1:0]        pop;

    // Game FSM next state; start/clear pulse on the transition edge
    always_comb begin
        game_d = game_q;
        start  = 1'b0;
        clear  = 1'b0;
        unique case (game_q)
            G_INIT: begin
                if (play_flag) begin
                    game_d = G_PLAY;
                    start  = 1'b1;
                end
            end
            G_PLAY: begin
                if (gameover_ctrl) begin
                    game_d = G_INIT;
                    clear  = 1'b1;
                end
            end
            default: game_d = G_INIT;
        endcase
    end

    // Game state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            game_q <= G_INIT;
        end else begin
            game_q <= game_d;
        end
    end

    assign q_Init = (game_q == G_INIT);
    assign q_Play = (game_q == G_PLAY);

    // Lowest-index armed requester wins the shared random_hex
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SHIELDS; i++) begin
            if (!found && armed[i] && break_req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Population count of broken channels
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SHIELDS; i++) begin
            pop = pop + CNT_W'(broken[i]);
        end
    end

    // Registered status outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            broken_count <= '0;
            all_broken   <= 1'b0;
            wrong_combo  <= 1'b0;
        end else begin
            broken_count <= pop;
            all_broken   <= &broken;
            wrong_combo  <= |mismatch;
        end
    end

    assign hull_breach = |hb;

    for (genvar g = 0; g < NUM_SHIELDS; g++) begin : g_chan
        nexys_starship_shield_chan #(
            .COMBO_W      (COMBO_W),
            .ARM_TICKS    (ARM_TICKS),
            .REPAIR_TICKS (REPAIR_TICKS)
        ) u_chan (
            .clk         (Clk),
            .reset       (Reset),
            .clear       (clear),
            .start       (start),
            .tick        (timer_tick),
            .grant       (grant[g]),
            .random_hex  (random_hex),
            .repair_btn  (repair_btn[g]),
            .hex_combo   (hex_combo),
            .armed       (armed[g]),
            .broken      (broken[g]),
            .combo       (combo_flat[g*COMBO_W +: COMBO_W]),
            .mismatch    (mismatch[g]),
            .hull_breach (hb[g])
        );
    end

endmodule

// File: tb/tb_nexys_starship_shield_bank.sv
// Directed vector bench for nexys_starship_shield_bank.
// Expects hull_breach pulses only when SHIELD_REPAIR_TIMEOUT_EN is defined.
module tb_nexys_starship_shield_bank;

`ifdef SHIELD_REPAIR_TIMEOUT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        timer_tick;
    logic        play_flag;
    logic        gameover_ctrl;
    logic [3:0]  break_req;
    logic [3:0]  random_hex;
    logic [3:0]  repair_btn;
    logic [3:0]  hex_combo;
    logic        q_Init;
    logic        q_Play;
    logic [3:0]  broken;
    logic [15:0] combo_flat;
    logic [2:0]  broken_count;
    logic        all_broken;
    logic        wrong_combo;
    logic        hull_breach;

    always #5 Clk = ~Clk;

    nexys_starship_shield_bank #(
        .NUM_SHIELDS  (4),
        .COMBO_W      (4),
        .ARM_TICKS    (2),
        .REPAIR_TICKS (3)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .timer_tick    (timer_tick),
        .play_flag     (play_flag),
        .gameover_ctrl (gameover_ctrl),
        .break_req     (break_req),
        .random_hex    (random_hex),
        .repair_btn    (repair_btn),
        .hex_combo     (hex_combo),
        .q_Init        (q_Init),
        .q_Play        (q_Play),
        .broken        (broken),
        .combo_flat    (combo_flat),
        .broken_count  (broken_count),
        .all_broken    (all_broken),
        .wrong_combo   (wrong_combo),
        .hull_breach   (hull_breach)
    );

    typedef struct {
        logic        rst;
        logic        tick;
        logic        play;
        logic        gover;
        logic [3:0]  brk;
        logic [3:0]  rhex;
        logic [3:0]  rbtn;
        logic [3:0]  hcmb;
        logic        e_init;
        logic        e_play;
        logic [3:0]  e_broken;
        logic [15:0] e_combo;
        logic [2:0]  e_cnt;
        logic        e_all;
        logic        e_wc;
        logic        e_hb;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic tick,
                       input logic play, input logic gover,
                       input logic [3:0] brk, input logic [3:0] rhex,
                       input logic [3:0] rbtn, input logic [3:0] hcmb,
                       input logic ei, input logic ep,
                       input logic [3:0] eb, input logic [15:0] ec,
                       input logic [2:0] en, input logic ea,
                       input logic ew, input logic eh);
        vec_t v;
        v.rst = rst; v.tick = tick; v.play = play; v.gover = gover;
        v.brk = brk; v.rhex = rhex; v.rbtn = rbtn; v.hcmb = hcmb;
        v.e_init = ei; v.e_play = ep; v.e_broken = eb; v.e_combo = ec;
        v.e_cnt = en; v.e_all = ea; v.e_wc = ew; v.e_hb = eh;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [30:0] act, exp;
        @(negedge Clk);
        Reset         = v.rst;
        timer_tick    = v.tick;
        play_flag     = v.play;
        gameover_ctrl = v.gover;
        break_req     = v.brk;
        random_hex    = v.rhex;
        repair_btn    = v.rbtn;
        hex_combo     = v.hcmb;
        @(posedge Clk);
        #1;
        act = {q_Init, q_Play, broken, combo_flat, broken_count,
               all_broken, wrong_combo, hull_breach};
        exp = {v.e_init, v.e_play, v.e_broken, v.e_combo, v.e_cnt,
               v.e_all, v.e_wc, v.e_hb};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got init=%b play=%b brk=%b combo=%h cnt=%0d all=%b wc=%b hb=%b, want init=%b play=%b brk=%b combo=%h cnt=%0d all=%b wc=%b hb=%b",
                     name, q_Init, q_Play, broken, combo_flat, broken_count,
                     all_broken, wrong_combo, hull_breach,
                     v.e_init, v.e_play, v.e_broken, v.e_combo, v.e_cnt,
                     v.e_all, v.e_wc, v.e_hb);
        end
    endtask

    task automatic step(input logic tick, input logic [3:0] brk,
                        input logic [3:0] rhex, input logic [3:0] rbtn,
                        input logic [3:0] hcmb, input logic [3:0] eb,
                        input logic [15:0] ec, input logic [2:0] en,
                        input logic ew, input string name);
        vec_t v;
        v.rst = 0; v.tick = tick; v.play = 0; v.gover = 0;
        v.brk = brk; v.rhex = rhex; v.rbtn = rbtn; v.hcmb = hcmb;
        v.e_init = 0; v.e_play = 1; v.e_broken = eb; v.e_combo = ec;
        v.e_cnt = en; v.e_all = 0; v.e_wc = ew; v.e_hb = 0;
        apply(v, name);
    endtask

    initial begin
        Reset = 1; timer_tick = 0; play_flag = 0; gameover_ctrl = 0;
        break_req = 0; random_hex = 0; repair_btn = 0; hex_combo = 0;

        //  rst tk pl go brk   rhx   rbtn  hcmb  I P brk   combo    n a w h
        add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1,0,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 0, 0, 4'hF, 4'hA, 4'h0, 4'h0, 1,0,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 0, 0, 4'h4, 4'hA, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 0, 0, 4'h4, 4'hA, 4'h0, 4'h0, 0,1,4'h4, 16'h0A00,0,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h4, 16'h0A00,1,0,0,0);
        add(0, 0, 0, 0, 4'hA, 4'h5, 4'h0, 4'h0, 0,1,4'h6, 16'h0A50,1,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h6, 16'h0A50,2,0,0,0);
        add(0, 0, 0, 0, 4'h8, 4'h7, 4'h0, 4'h0, 0,1,4'hE, 16'h7A50,2,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h3, 0,1,4'hE, 16'h7A50,3,0,1,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'hE, 16'h7A50,3,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h5, 0,1,4'hC, 16'h7A50,3,0,0,0);
        add(0, 0, 0, 0, 4'h2, 4'h1, 4'h0, 4'h0, 0,1,4'hC, 16'h7A50,2,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'hC, 16'h7A50,2,0,0,0);
        add(0, 0, 0, 0, 4'h3, 4'h2, 4'h0, 4'h0, 0,1,4'hD, 16'h7A52,2,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'hD, 16'h7A52,3,0,0,0);
        add(0, 0, 0, 0, 4'h2, 4'h9, 4'h8, 4'h7, 0,1,4'h7, 16'h7A92,3,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h7, 16'h7A92,3,0,0,0);
        add(0, 0, 0, 0, 4'h8, 4'hB, 4'h0, 4'h0, 0,1,4'h7, 16'h7A92,3,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h7, 16'h7A92,3,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h7, 16'h7A92,3,0,0,0);
        add(0, 0, 0, 0, 4'h8, 4'hC, 4'h0, 4'h0, 0,1,4'hF, 16'hCA92,3,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'hF, 16'hCA92,4,1,0,0);
        add(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1,0,4'h0, 16'h0000,4,1,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1,0,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 0, 0, 4'h1, 4'h6, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,0,0,0,0);
        add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1,0,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1,0,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 0, 0, 4'hF, 4'h6, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h0, 16'h0000,0,0,0,0);
        add(0, 0, 0, 0, 4'h1, 4'h6, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,0,0,0,0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,HB);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);
        add(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,HB);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0,1,4'h1, 16'h0006,1,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // Two channels mismatch together: one single-cycle wrong_combo pulse
        step(0, 4'h2, 4'h3, 4'h0, 4'h0, 4'h3, 16'h0036, 1, 0, "brk_ch1");
        step(0, 4'h0, 4'h0, 4'h3, 4'hF, 4'h3, 16'h0036, 2, 1, "dual_wrong");
        step(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 16'h0036, 2, 0, "wc_drop");
        step(0, 4'h0, 4'h0, 4'h1, 4'h6, 4'h2, 16'h0036, 2, 0, "fix_ch0");
        step(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 16'h0036, 1, 0, "cnt_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nexys_starship_shield_bank.md
Name: nexys_starship_shield_bank

Overview:
- Parametrised successor to the single-direction shield controller.
- Manages NUM_SHIELDS independent shield channels behind one game FSM.
- Each channel: arms after a tick delay, breaks on a random request (latching a repair combo), and repairs on a button press with a matching hex combo.
- Sits between the random/timer generators and the display/game-over logic; reports per-channel status, a broken count and an all-broken flag.

Parameters:
- NUM_SHIELDS, 4: number of shield channels (1..8).
- COMBO_W, 4: width of the repair combo in bits.
- ARM_TICKS, 2: timer_tick pulses a channel spends in ARMING before it can break (1..255).
- REPAIR_TICKS, 30: repair deadline in ticks; used only with SHIELD_REPAIR_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- timer_tick  in  1  one-Clk-wide pulse, Clk-synchronous slow time base.
- play_flag  in  1  starts play from INIT.
- gameover_ctrl  in  1  forces return to INIT.
- break_req  in  NUM_SHIELDS  per-channel random break request.
- random_hex  in  COMBO_W  combo captured on a break.
- repair_btn  in  NUM_SHIELDS  per-channel repair button, pre-debounced single-cycle pulse.
- hex_combo  in  COMBO_W  player-entered combo.
- q_Init, q_Play  out  1 each  one-hot game state.
- broken  out  NUM_SHIELDS  channel broken flags.
- combo_flat  out  NUM_SHIELDS*COMBO_W  latched combos; channel i occupies bits [i*COMBO_W +: COMBO_W].
- broken_count  out  $clog2(NUM_SHIELDS+1)  population count of broken.
- all_broken  out  1  registered; high when every channel is broken.
- wrong_combo  out  1  one-cycle pulse on a mismatched repair attempt.
- hull_breach  out  1  one-cycle pulse; only with the optional feature, else tied 0.

Behaviour:
- Reset (synchronous): game state INIT; every channel IDLE; broken=0; combo_flat=0; broken_count=0; all_broken=0; wrong_combo=0; hull_breach=0.
- Game FSM:
  - INIT -> PLAY when play_flag.
  - PLAY -> INIT when gameover_ctrl.
  - Entering INIT forces all channels to IDLE and clears broken and combos on that same edge.
- Channel FSM, with i = channel index:
  - IDLE -> ARMING on the cycle the game enters PLAY; tick counter cleared.
  - ARMING: counter increments on each timer_tick; -> ARMED on the tick that makes the count equal ARM_TICKS.
  - ARMED -> BROKEN when break_req[i] and channel i is the grant winner (see below). combo[i] <= random_hex; broken[i] <= 1 on the same edge.
  - BROKEN: on repair_btn[i], if hex_combo == combo[i], go to ARMING with counter 0 and broken[i] <= 0, re-arming the delay. Otherwise stay BROKEN and pulse wrong_combo for one cycle.
  - break_req is ignored outside ARMED. repair_btn is ignored outside BROKEN.
- Break arbitration: random_hex is shared, so at most one channel breaks per Clk. Among channels in ARMED with break_req set, the lowest index wins. Losers stay ARMED; the request is not queued.
- Simultaneous events, in priority order: Reset > gameover_ctrl > repair > break. A repair and a break on different channels in the same cycle are both honoured.
- Registered outputs, latency 1 Clk after the cause:
  - broken_count.
  - all_broken.
  - wrong_combo: when several channels mismatch in one cycle, a single pulse.
- Width rules: tick counter is 8 bits and saturates at ARM_TICKS. combo comparison is exact over COMBO_W bits.

Optional Feature:
- Macro: SHIELD_REPAIR_TIMEOUT_EN.
- Enabled:
  - Each BROKEN channel counts timer_tick.
  - Reaching REPAIR_TICKS pulses hull_breach for one Clk and reloads the counter to 0. The channel stays BROKEN and the pulse repeats every REPAIR_TICKS ticks.
  - A successful repair clears the counter.
- Disabled: no timeout counters are built and hull_breach is constant 0.

Decomposition:
- Package nexys_starship_pkg holds:
  - channel state encodings IDLE/ARMING/ARMED/BROKEN, one-hot 4 bits;
  - game state encodings INIT/PLAY;
  - the tick-counter width constant.
- Sub-module nexys_starship_shield_chan implements one channel FSM, its counters and its combo register. It is instantiated NUM_SHIELDS times in a generate loop.
- Arbitration, popcount, wrong_combo OR-reduction and the game FSM stay in the top level.

Test Plan:
- Reset, then play_flag, then 2 ticks with ARM_TICKS=2 -> all channels ARMED exactly on the 2nd tick edge. break_req=4'b0100, random_hex=4'hA -> broken=4'b0100, combo[2]=A, broken_count=1 one cycle later.
- break_req=4'b1010 in one cycle, both ARMED -> only channel 1 breaks; channel 3 remains ARMED; broken=4'b0010.
- Channel 1 broken with combo 5: repair_btn[1] with hex_combo=3 -> wrong_combo pulse, still broken. Then hex_combo=5 -> broken[1]=0 and channel back in ARMING with counter 0.
- Break all 4 channels -> all_broken=1 and broken_count=4. Assert gameover_ctrl -> next edge INIT, broken=0, combo_flat=0.
- Reset asserted mid-ARMING and mid-BROKEN -> all outputs at reset values on the next edge. break_req in INIT -> ignored.
- With SHIELD_REPAIR_TIMEOUT_EN and REPAIR_TICKS=3: leave channel 0 broken for 6 ticks -> hull_breach pulses on ticks 3 and 6. Without the macro -> hull_breach stays 0.
